pingpong_line_ctrl: RTL and testbench

// Sequencer for the two-bank ping-pong line buffer of the preprocessing front end.

---
 rtl/pingpong_line_ctrl.sv | 144 ++++++++++++++
 tb/tb_pingpong_line_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pingpong_line_ctrl.sv
// rtl/pingpong_line_ctrl.sv - two-bank ping-pong line buffer sequencer
// Steers input beats into the filling bank and drains full banks line by line.
module pingpong_line_ctrl #(
    parameter int M          = 240,
    parameter int P          = 8,
    parameter int LINES      = 240,
    localparam int BEATS     = M / P,
    localparam int AW        = $clog2(BEATS),
    localparam int LW        = $clog2(LINES)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_frame_start,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    output logic [1:0]    o_wr_en,
    output logic [AW-1:0] o_wr_addr,
    output logic [1:0]    o_rd_en,
    output logic [AW-1:0] o_rd_addr,
    input  logic          i_out_ready,
    output logic          o_out_valid,
    output logic          o_out_bank,
    output logic          o_out_last,
    output logic [LW-1:0] o_line_idx,
    output logic          o_frame_done,
    output logic          o_busy
);
    // Line counters need one extra bit so they can hold LINES itself.
    localparam int CW = LW + 1;
    localparam logic [1:0]    ST_EMPTY  = 2'd0;
    localparam logic [1:0]    ST_FILL   = 2'd1;
    localparam logic [1:0]    ST_FULL   = 2'd2;
    localparam logic [1:0]    ST_DRAIN  = 2'd3;
    localparam logic [AW-1:0] LAST_ADDR = AW'(BEATS - 1);
    localparam logic [CW-1:0] LINES_C   = CW'(LINES);
    localparam logic [CW-1:0] LAST_LINE = CW'(LINES - 1);

    logic [1:0][1:0] bank_st;
    logic            wr_sel;
    logic            rd_sel;
    logic            busy;
    logic [AW-1:0]   wr_addr;
    logic [AW-1:0]   rd_addr;
    logic [CW-1:0]   wr_lines;
    logic [CW-1:0]   rd_lines;
    logic            out_valid;
    logic            out_bank;
    logic            out_last;
    logic            frame_done;

    logic [1:0]      wr_st;
    logic [1:0]      rd_st;
    logic            in_ready;
    logic            accept;
    logic            wr_last;
    logic            issue;
    logic            rd_last;
    logic            frame_end;

    // FILL/EMPTY have bit1 clear, FULL/DRAIN have it set.
    always_comb begin
        wr_st     = bank_st[wr_sel];
        rd_st     = bank_st[rd_sel];
        in_ready  = busy && (wr_lines < LINES_C) && !wr_st[1];
        accept    = i_in_valid && in_ready;
        wr_last   = accept && (wr_addr == LAST_ADDR);
        issue     = i_out_ready && rd_st[1];
        rd_last   = issue && (rd_addr == LAST_ADDR);
        frame_end = rd_last && (rd_lines == LAST_LINE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bank_st    <= {ST_EMPTY, ST_EMPTY};
            wr_sel     <= 1'b0;
            rd_sel     <= 1'b0;
            busy       <= 1'b0;
            wr_addr    <= '0;
            rd_addr    <= '0;
            wr_lines   <= '0;
            rd_lines   <= '0;
            out_valid  <= 1'b0;
            out_bank   <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (i_frame_start && !busy) begin
                busy     <= 1'b1;
                wr_lines <= '0;
                rd_lines <= '0;
            end
            if (accept) begin
                if (wr_last) begin
                    wr_addr          <= '0;
                    bank_st[wr_sel]  <= ST_FULL;
                    wr_sel           <= ~wr_sel;
                    wr_lines         <= wr_lines + 1'b1;
                end else begin
                    wr_addr          <= wr_addr + 1'b1;
                    bank_st[wr_sel]  <= ST_FILL;
                end
            end
            // Write and read always touch different banks: their states are disjoint.
            if (issue) begin
                if (rd_last) begin
                    rd_addr          <= '0;
                    bank_st[rd_sel]  <= ST_EMPTY;
                    rd_sel           <= ~rd_sel;
                    rd_lines         <= rd_lines + 1'b1;
                end else begin
                    rd_addr          <= rd_addr + 1'b1;
                    bank_st[rd_sel]  <= ST_DRAIN;
                end
            end
            if (frame_end) begin
                busy <= 1'b0;
            end
            out_valid  <= issue;
            out_bank   <= rd_sel;
            out_last   <= rd_last;
            frame_done <= frame_end;
        end
    end

    assign o_in_ready   = in_ready;
    assign o_wr_en      = {accept & wr_sel, accept & ~wr_sel};
    assign o_wr_addr    = wr_addr;
    assign o_rd_en      = {issue & rd_sel, issue & ~rd_sel};
    assign o_rd_addr    = rd_addr;
    assign o_out_valid  = out_valid;
    assign o_out_bank   = out_bank;
    assign o_out_last   = out_last;
    assign o_line_idx   = rd_lines[LW-1:0];
    assign o_frame_done = frame_done;
    assign o_busy       = busy;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert ((o_wr_en & o_rd_en) == 2'b00);
            assert (o_wr_en != 2'b11);
            assert (o_rd_en != 2'b11);
        end
    end
endmodule

// File: tb/tb_pingpong_line_ctrl.sv
// tb/tb_pingpong_line_ctrl.sv - randomized self-checking bench for pingpong_line_ctrl
module tb_pingpong_line_ctrl;
    localparam int M     = 240;
    localparam int P     = 8;
    localparam int LINES = 4;
    localparam int BEATS = M / P;
    localparam int AW    = $clog2(BEATS);
    localparam int LW    = $clog2(LINES);

    logic          clk = 1'b0;
    logic          rst;
    logic          fs;
    logic          iv;
    logic          ordy;
    logic          o_in_ready;
    logic [1:0]    o_wr_en;
    logic [AW-1:0] o_wr_addr;
    logic [1:0]    o_rd_en;
    logic [AW-1:0] o_rd_addr;
    logic          o_out_valid;
    logic          o_out_bank;
    logic          o_out_last;
    logic [LW-1:0] o_line_idx;
    logic          o_frame_done;
    logic          o_busy;

    pingpong_line_ctrl #(.M(M), .P(P), .LINES(LINES)) dut (
        .i_clk(clk), .i_rst(rst), .i_frame_start(fs), .i_in_valid(iv),
        .o_in_ready(o_in_ready), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
        .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_out_ready(ordy),
        .o_out_valid(o_out_valid), .o_out_bank(o_out_bank), .o_out_last(o_out_last),
        .o_line_idx(o_line_idx), .o_frame_done(o_frame_done), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: lines written/read and beat positions; line n lives in bank n%2.
    int m_busy, m_wl, m_rl, m_wb, m_rb;
    int e_ov, e_ob, e_ol, e_fd;
    int n_ov, n_ol, n_fd, fd_at, n_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_wl = 0; m_rl = 0; m_wb = 0; m_rb = 0;
        e_ov = 0; e_ob = 0; e_ol = 0; e_fd = 0;
    endtask

    task automatic clear_counts();
        n_ov = 0; n_ol = 0; n_fd = 0; fd_at = -1; n_acc = 0;
    endtask

    task automatic step(input bit v, input bit r, input bit f);
        bit rdy, acc, iss, last, fd;
        int wsel, rsel, busy_pre;
        iv = v; ordy = r; fs = f;
        @(negedge clk);
        busy_pre = m_busy;
        rdy  = (m_busy != 0) && (m_wl < LINES) && ((m_wl - m_rl) < 2);
        acc  = v && rdy;
        wsel = m_wl % 2;
        iss  = r && (m_rl < m_wl);
        rsel = m_rl % 2;
        chk("in_ready", 32'(o_in_ready), 32'(rdy));
        chk("wr_en", 32'(o_wr_en), acc ? 32'(1 << wsel) : 32'd0);
        if (acc) chk("wr_addr", 32'(o_wr_addr), 32'(m_wb));
        chk("rd_en", 32'(o_rd_en), iss ? 32'(1 << rsel) : 32'd0);
        if (iss) chk("rd_addr", 32'(o_rd_addr), 32'(m_rb));
        chk("out_valid", 32'(o_out_valid), 32'(e_ov));
        if (e_ov != 0) begin
            chk("out_bank", 32'(o_out_bank), 32'(e_ob));
            chk("out_last", 32'(o_out_last), 32'(e_ol));
        end
        chk("frame_done", 32'(o_frame_done), 32'(e_fd));
        chk("busy", 32'(o_busy), 32'(m_busy));
        chk("line_idx", 32'(o_line_idx), 32'(m_rl % (1 << LW)));
        n_ov  += int'(o_out_valid);
        n_ol  += int'(o_out_valid && o_out_last);
        n_acc += int'(o_wr_en != 2'b00);
        if (o_frame_done) begin
            n_fd++;
            fd_at = n_ov;
        end
        if (acc) begin
            m_wb++;
            if (m_wb == BEATS) begin m_wb = 0; m_wl++; end
        end
        last = 1'b0; fd = 1'b0;
        if (iss) begin
            last = (m_rb == BEATS - 1);
            fd   = last && (m_rl == LINES - 1);
            m_rb++;
            if (last) begin m_rb = 0; m_rl++; end
        end
        e_ov = int'(iss); e_ob = rsel; e_ol = int'(last); e_fd = int'(fd);
        if (fd) m_busy = 0;
        if (f && busy_pre == 0) begin
            m_busy = 1; m_wl = 0; m_rl = 0;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; iv = 1'b1; ordy = 1'b1; fs = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(o_in_ready), 0);
        chk("rst_wr_en", 32'(o_wr_en), 0);
        chk("rst_rd_en", 32'(o_rd_en), 0);
        chk("rst_wr_addr", 32'(o_wr_addr), 0);
        chk("rst_rd_addr", 32'(o_rd_addr), 0);
        chk("rst_out_valid", 32'(o_out_valid), 0);
        chk("rst_out_last", 32'(o_out_last), 0);
        chk("rst_frame_done", 32'(o_frame_done), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_line_idx", 32'(o_line_idx), 0);
        @(posedge clk); #1;
        rst = 1'b0; iv = 1'b0; ordy = 1'b0;
        model_reset();
    endtask

    task automatic finish_frame(input int mode);
        bit v, r, f;
        for (int i = 0; i < 3000 && m_busy != 0; i++) begin
            v = 1'b1; r = 1'b1; f = 1'b0;
            case (mode)
                1: r = (i % 2) == 1;
                2: begin v = ($urandom % 2) == 1; r = ($urandom_range(0, 3) != 0); end
                3: f = (i == 40) || (i == 150);
                default: ;
            endcase
            step(v, r, f);
        end
        step(1'b0, 1'b0, 1'b0);
        chk("frame_timeout_busy", 32'(o_busy), 0);
        chk("frame_beats", 32'(n_ov), LINES * BEATS);
        chk("frame_lasts", 32'(n_ol), LINES);
        chk("frame_done_count", 32'(n_fd), 1);
        chk("frame_done_at_beat", 32'(fd_at), LINES * BEATS);
        chk("frame_accepts", 32'(n_acc), LINES * BEATS);
    endtask

    task automatic run_frame(input int mode);
        clear_counts();
        step(1'b0, 1'b1, 1'b1);
        finish_frame(mode);
    endtask

    initial begin
        bit reached;
        rst = 1'b1; fs = 1'b0; iv = 1'b0; ordy = 1'b0;
        model_reset();
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
        chk("idle_busy", 32'(o_busy), 0);

        run_frame(0);

        // Stalled drain: two lines fit, the rest is refused until a bank frees.
        clear_counts();
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 70; i++) step(1'b1, 1'b0, 1'b0);
        chk("stall_accepts", 32'(n_acc), 2 * BEATS);
        chk("stall_no_valid", 32'(n_ov), 0);
        chk("stall_in_ready", 32'(o_in_ready), 0);
        finish_frame(0);

        run_frame(1);

        // Reset while reading beat 15 of line 2.
        clear_counts();
        step(1'b0, 1'b1, 1'b1);
        reached = 1'b0;
        for (int i = 0; i < 3000 && !reached; i++) begin
            if (m_rl == 2 && m_rb == 15) reached = 1'b1;
            else step(($urandom % 2) == 1, 1'b1, 1'b0);
        end
        chk("reach_line2_beat15", 32'(reached), 1);
        do_reset();
        run_frame(2);

        run_frame(3);
        run_frame(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
